gray_ptr_sync_decoder: RTL and testbench

Receive-side counterpart of the binary-to-Gray pointer encoder in the asynchronous FIFO. Samples a Gray-coded pointer launched from a foreign clock domain through a multi-flop synchronizer, decodes it back to binary, and reports how far the pointer advanced since the previous decoded value. The FIFO's full/empty and occupancy logic in the local domain consumes its outputs.

---
 rtl/gray_ptr_sync_decoder.sv | 40 ++++
 tb/tb_gray_ptr_sync_decoder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/gray_ptr_sync_decoder.sv
// gray_ptr_sync_decoder: synchronizes a foreign-domain Gray pointer, decodes it to binary,
// and reports the modulo advance since the previous decoded value.
module gray_ptr_sync_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_sync,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] delta,
    output logic             changed
);
    logic [WIDTH-1:0] s [SYNC_STAGES];
    logic [WIDTH-1:0] dec;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) s[k] <= '0;
        end else begin
            s[0] <= gray_in;
            for (int k = 1; k < SYNC_STAGES; k++) s[k] <= s[k-1];
        end
    end
    assign gray_sync = s[SYNC_STAGES-1];
    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign dec[i] = ^gray_sync[WIDTH-1:i];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out <= '0;
            delta   <= '0;
            changed <= 1'b0;
        end else begin
            bin_out <= dec;
            changed <= dec != bin_out;
            if (dec != bin_out) delta <= dec - bin_out;
        end
    end
endmodule

// File: tb/tb_gray_ptr_sync_decoder.sv
// tb_gray_ptr_sync_decoder: directed checks of sync latency, decode, delta and reset behaviour.
module tb_gray_ptr_sync_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] gray_in = 4'b0000;
    logic [3:0] gray_sync, bin_out, delta;
    logic       changed;
    int total = 0;
    int bad = 0;

    gray_ptr_sync_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in),
        .gray_sync(gray_sync), .bin_out(bin_out), .delta(delta), .changed(changed)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        gray_in = 4'b0110;
        repeat (3) step();
        total++; if (gray_sync !== 4'd0) begin bad++; $display("FAIL reset_gray_sync got=%b exp=0000", gray_sync); end
        total++; if (bin_out !== 4'd0) begin bad++; $display("FAIL reset_bin_out got=%0d exp=0", bin_out); end
        total++; if (delta !== 4'd0) begin bad++; $display("FAIL reset_delta got=%0d exp=0", delta); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL reset_changed got=%b exp=0", changed); end
        gray_in = 4'b0000;
        #2 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            total++; if (changed !== 1'b0 || bin_out !== 4'd0) begin bad++; $display("FAIL post_reset_quiet cyc=%0d changed=%b bin=%0d exp changed=0 bin=0", c, changed, bin_out); end
        end
    endtask

    task automatic test_latency();
        gray_in = 4'b0001;
        step();
        total++; if (gray_sync !== 4'b0000) begin bad++; $display("FAIL lat_e0_gray_sync got=%b exp=0000", gray_sync); end
        step();
        total++; if (gray_sync !== 4'b0001 || bin_out !== 4'd0) begin bad++; $display("FAIL lat_e1 gray_sync=%b bin=%0d exp 0001/0", gray_sync, bin_out); end
        step();
        total++; if (bin_out !== 4'd1 || changed !== 1'b1 || delta !== 4'd1) begin bad++; $display("FAIL lat_e2 bin=%0d changed=%b delta=%0d exp 1/1/1", bin_out, changed, delta); end
        step();
        total++; if (changed !== 1'b0 || bin_out !== 4'd1) begin bad++; $display("FAIL lat_e3 changed=%b bin=%0d exp 0/1", changed, bin_out); end
    endtask

    task automatic test_sweep();
        int pulses;
        gray_in = 4'b0000;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (changed) begin
                pulses++;
                total++; if (delta !== 4'd15 || bin_out !== 4'd0) begin bad++; $display("FAIL backward_delta delta=%0d bin=%0d exp 15/0", delta, bin_out); end
            end
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL backward_pulses got=%0d exp=1", pulses); end
        pulses = 0;
        for (int b = 1; b <= 16; b++) begin
            gray_in = to_gray(b % 16);
            for (int c = 0; c < 4; c++) begin
                step();
                if (changed) begin
                    pulses++;
                    total++; if (delta !== 4'd1 || bin_out !== 4'(b % 16)) begin bad++; $display("FAIL sweep_pulse b=%0d delta=%0d bin=%0d exp delta=1 bin=%0d", b % 16, delta, bin_out, b % 16); end
                end
            end
            total++; if (bin_out !== 4'(b % 16)) begin bad++; $display("FAIL sweep_bin got=%0d exp=%0d", bin_out, b % 16); end
        end
        total++; if (pulses !== 16) begin bad++; $display("FAIL sweep_pulses got=%0d exp=16", pulses); end
    endtask

    task automatic test_jump();
        int pulses;
        gray_in = 4'b0010;
        repeat (4) step();
        total++; if (bin_out !== 4'd3) begin bad++; $display("FAIL jump_start_bin got=%0d exp=3", bin_out); end
        gray_in = 4'b0110;
        #1 gray_in = 4'b0111;
        #1 gray_in = 4'b0101;
        #1 gray_in = 4'b0100;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (changed) begin
                pulses++;
                total++; if (bin_out !== 4'd7 || delta !== 4'd4) begin bad++; $display("FAIL jump_pulse bin=%0d delta=%0d exp 7/4", bin_out, delta); end
            end
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL jump_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_back_to_back();
        gray_in = 4'b0000;
        repeat (4) step();
        gray_in = to_gray(1);
        step();
        gray_in = to_gray(2);
        step();
        gray_in = to_gray(3);
        for (int b = 1; b <= 3; b++) begin
            step();
            total++; if (changed !== 1'b1 || delta !== 4'd1 || bin_out !== 4'(b)) begin bad++; $display("FAIL b2b_pulse%0d changed=%b delta=%0d bin=%0d exp 1/1/%0d", b, changed, delta, bin_out, b); end
        end
        step();
        total++; if (changed !== 1'b0 || bin_out !== 4'd3) begin bad++; $display("FAIL b2b_end changed=%b bin=%0d exp 0/3", changed, bin_out); end
    endtask

    task automatic test_mid_reset();
        gray_in = 4'b1101;
        repeat (4) step();
        total++; if (bin_out !== 4'd9) begin bad++; $display("FAIL midrst_pre_bin got=%0d exp=9", bin_out); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (gray_sync !== 4'd0 || bin_out !== 4'd0 || delta !== 4'd0 || changed !== 1'b0) begin bad++; $display("FAIL midrst_clear gray_sync=%b bin=%0d delta=%0d changed=%b exp all 0", gray_sync, bin_out, delta, changed); end
        gray_in = 4'b0000;
        #2 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            total++; if (changed !== 1'b0 || bin_out !== 4'd0) begin bad++; $display("FAIL midrst_quiet cyc=%0d changed=%b bin=%0d exp 0/0", c, changed, bin_out); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sweep();
        test_jump();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
